clk_period_monitor: RTL and testbench



---
 rtl/clk_period_monitor.sv | 144 ++++++++++++++
 tb/tb_clk_period_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_monitor.sv
// Synchronises a slow square wave, emits rise/fall strobes and checks its half-period for lock.
// Optional sticky error output enabled by defining CLK_PERIOD_MON_STICKY_ERR_EN.
module clk_period_monitor #(
  parameter int unsigned MAX_HALF_PERIOD = 1024,
  parameter int unsigned TOLERANCE       = 1,
  parameter int unsigned LOCK_COUNT      = 4,
  localparam int unsigned CNT_W          = $clog2(MAX_HALF_PERIOD + 1)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] expected_half,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
`ifdef CLK_PERIOD_MON_STICKY_ERR_EN
  ,
  output logic             err_sticky
`endif
);

  localparam int unsigned MC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MaxM1   = CNT_W'(MAX_HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] TolW    = CNT_W'(TOLERANCE);
  localparam logic [MC_W-1:0]  McOne   = MC_W'(1);
  localparam logic [MC_W-1:0]  LockCnt = MC_W'(LOCK_COUNT);

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  logic             period_valid_q, period_valid_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;

  logic             edge_det;
  logic [CNT_W-1:0] meas;
  logic [CNT_W-1:0] diff;
  logic             is_match;
  logic             timeout_cond;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      state_q        <= StIdle;
      half_cnt_q     <= '0;
      half_period_q  <= '0;
      period_valid_q <= 1'b0;
      match_cnt_q    <= '0;
    end else begin
      sync1_q        <= sig_in;
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      state_q        <= state_d;
      half_cnt_q     <= half_cnt_d;
      half_period_q  <= half_period_d;
      period_valid_q <= period_valid_d;
      match_cnt_q    <= match_cnt_d;
    end
  end

  always_comb begin
    rise_pulse   = sync2_q & ~prev_q;
    fall_pulse   = ~sync2_q & prev_q;
    edge_det     = rise_pulse | fall_pulse;
    meas         = half_cnt_q + CntOne;
    // Unsigned absolute difference without wrap.
    diff         = (meas >= expected_half) ? (meas - expected_half) : (expected_half - meas);
    is_match     = (diff <= TolW);
    timeout_cond = (state_q != StIdle) && !edge_det && (half_cnt_q == MaxM1);
  end

  always_comb begin
    state_d        = state_q;
    half_cnt_d     = half_cnt_q;
    half_period_d  = half_period_q;
    period_valid_d = 1'b0;
    match_cnt_d    = match_cnt_q;
    unique case (state_q)
      StIdle: begin
        half_cnt_d = '0;
        if (edge_det) begin
          state_d     = StAcquire;
          match_cnt_d = '0;
        end
      end
      StAcquire, StLocked: begin
        if (edge_det) begin
          half_cnt_d     = '0;
          half_period_d  = meas;
          period_valid_d = 1'b1;
          if (state_q == StAcquire) begin
            if (is_match) begin
              match_cnt_d = match_cnt_q + McOne;
              if (match_cnt_q + McOne == LockCnt) state_d = StLocked;
            end else begin
              match_cnt_d = '0;
            end
          end else if (!is_match) begin
            state_d     = StAcquire;
            match_cnt_d = '0;
          end
        end else if (timeout_cond) begin
          state_d    = StIdle;
          half_cnt_d = '0;
        end else begin
          half_cnt_d = half_cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign locked       = (state_q == StLocked);
  assign timeout      = timeout_cond;

`ifdef CLK_PERIOD_MON_STICKY_ERR_EN
  logic err_q;
  logic err_set;

  assign err_set = ((state_q == StLocked) && edge_det && !is_match) || timeout_cond;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: lock-in, tolerance, loss, timeout, edge-vs-timeout, async reset.
module tb_clk_period_monitor;

  localparam int unsigned MaxHp = 16;
  localparam int unsigned Cw    = $clog2(MaxHp + 1);

  logic          clk_in = 1'b0;
  logic          reset;
  logic          sig_in;
  logic [Cw-1:0] expected_half;
  logic          rise_pulse, fall_pulse, period_valid, locked, timeout;
  logic [Cw-1:0] half_period;
`ifdef CLK_PERIOD_MON_STICKY_ERR_EN
  logic          err_sticky;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Observations captured by edge_after
  logic          e_pulse, e_lk, e_to, o_pv, o_lk;
  logic [Cw-1:0] o_hp;

  clk_period_monitor #(
    .MAX_HALF_PERIOD(MaxHp),
    .TOLERANCE      (1),
    .LOCK_COUNT     (4)
  ) u_dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .sig_in       (sig_in),
    .expected_half(expected_half),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
`ifdef CLK_PERIOD_MON_STICKY_ERR_EN
    ,
    .err_sticky   (err_sticky)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Toggle sig_in h cycles after the previous toggle (h >= 3), then observe the
  // edge strobe two cycles later and the measurement one cycle after that.
  task automatic edge_after(input int h);
    repeat (h - 3) @(negedge clk_in);
    sig_in = ~sig_in;
    repeat (2) @(negedge clk_in);
    e_pulse = sig_in ? rise_pulse : fall_pulse;
    e_lk    = locked;
    e_to    = timeout;
    @(negedge clk_in);
    o_pv = period_valid;
    o_hp = half_period;
    o_lk = locked;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sig_in = 1'b0;
    expected_half = 5'd4;
    repeat (2) @(negedge clk_in);
    n_total++;
    if ({rise_pulse, fall_pulse, period_valid, locked, timeout} !== 5'b0)
      $display("FAIL reset_flags: got %05b want 00000",
               {rise_pulse, fall_pulse, period_valid, locked, timeout});
    else n_pass++;
    n_total++;
    if (half_period !== '0) $display("FAIL reset_hp: got %0d want 0", half_period);
    else n_pass++;
`ifdef CLK_PERIOD_MON_STICKY_ERR_EN
    n_total++;
    if (err_sticky !== 1'b0) $display("FAIL reset_err: got %0b want 0", err_sticky);
    else n_pass++;
`endif
    reset = 1'b0;
  endtask

  task automatic test_lock();
    edge_after(4);
    n_total++;
    if (e_pulse !== 1'b1) $display("FAIL lock_first_pulse: got %0b want 1", e_pulse);
    else n_pass++;
    n_total++;
    if (o_pv !== 1'b0) $display("FAIL lock_first_pv: got %0b want 0", o_pv);
    else n_pass++;
    for (int i = 2; i <= 5; i++) begin
      edge_after(4);
      n_total++;
      if (o_pv !== 1'b1 || o_hp !== 5'd4)
        $display("FAIL lock_meas%0d: got pv=%0b hp=%0d want pv=1 hp=4", i, o_pv, o_hp);
      else n_pass++;
      n_total++;
      if (o_lk !== (i == 5))
        $display("FAIL lock_state%0d: got %0b want %0b", i, o_lk, (i == 5));
      else n_pass++;
    end
`ifdef CLK_PERIOD_MON_STICKY_ERR_EN
    n_total++;
    if (err_sticky !== 1'b0) $display("FAIL lock_err: got %0b want 0", err_sticky);
    else n_pass++;
`endif
  endtask

  task automatic test_tolerance();
    edge_after(5);
    n_total++;
    if (o_pv !== 1'b1 || o_hp !== 5'd5 || o_lk !== 1'b1)
      $display("FAIL tol_plus1: got pv=%0b hp=%0d lk=%0b want 1 5 1", o_pv, o_hp, o_lk);
    else n_pass++;
    edge_after(3);
    n_total++;
    if (o_hp !== 5'd3 || o_lk !== 1'b1)
      $display("FAIL tol_minus1: got hp=%0d lk=%0b want 3 1", o_hp, o_lk);
    else n_pass++;
    edge_after(6);
    n_total++;
    if (o_hp !== 5'd6 || e_lk !== 1'b1 || o_lk !== 1'b0)
      $display("FAIL tol_plus2: got hp=%0d lk_edge=%0b lk=%0b want 6 1 0", o_hp, e_lk, o_lk);
    else n_pass++;
`ifdef CLK_PERIOD_MON_STICKY_ERR_EN
    n_total++;
    if (err_sticky !== 1'b1) $display("FAIL tol_err: got %0b want 1", err_sticky);
    else n_pass++;
`endif
  endtask

  task automatic relock(input string tag);
    for (int i = 1; i <= 4; i++) begin
      edge_after(4);
      n_total++;
      if (o_lk !== (i == 4))
        $display("FAIL %s_relock%0d: got %0b want %0b", tag, i, o_lk, (i == 4));
      else n_pass++;
    end
  endtask

  task automatic test_loss();
    relock("loss_pre");
    edge_after(7);
    n_total++;
    if (o_pv !== 1'b1 || o_hp !== 5'd7)
      $display("FAIL loss_meas: got pv=%0b hp=%0d want 1 7", o_pv, o_hp);
    else n_pass++;
    n_total++;
    if (e_lk !== 1'b1 || o_lk !== 1'b0)
      $display("FAIL loss_lock: got edge=%0b next=%0b want 1 0", e_lk, o_lk);
    else n_pass++;
    // Match counter restarted: exactly four more matches needed
    relock("loss_post");
  endtask

  task automatic test_timeout();
    int to_count;
    int to_idx;
    edge_after(4);
    n_total++;
    if (o_lk !== 1'b1) $display("FAIL to_pre_lock: got %0b want 1", o_lk);
    else n_pass++;
    to_count = 0;
    to_idx   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_in);
      if (timeout === 1'b1) begin
        to_count++;
        to_idx = i;
      end
      if (i == 15) begin
        n_total++;
        if (locked !== 1'b1) $display("FAIL to_lock_t15: got %0b want 1", locked);
        else n_pass++;
      end
      if (i == 16) begin
        n_total++;
        if (locked !== 1'b0) $display("FAIL to_lock_t16: got %0b want 0", locked);
        else n_pass++;
      end
    end
    n_total++;
    if (to_count != 1 || to_idx != 15)
      $display("FAIL to_strobe: got count=%0d at=%0d want 1 at 15", to_count, to_idx);
    else n_pass++;
    n_total++;
    if (half_period !== 5'd4) $display("FAIL to_hp_hold: got %0d want 4", half_period);
    else n_pass++;
`ifdef CLK_PERIOD_MON_STICKY_ERR_EN
    n_total++;
    if (err_sticky !== 1'b1) $display("FAIL to_err: got %0b want 1", err_sticky);
    else n_pass++;
`endif
    edge_after(4);
    n_total++;
    if (e_pulse !== 1'b1 || o_pv !== 1'b0)
      $display("FAIL to_idle_edge: got pulse=%0b pv=%0b want 1 0", e_pulse, o_pv);
    else n_pass++;
  endtask

  task automatic test_edge_wins();
    edge_after(16);
    n_total++;
    if (e_to !== 1'b0) $display("FAIL edgewin_timeout: got %0b want 0", e_to);
    else n_pass++;
    n_total++;
    if (o_pv !== 1'b1 || o_hp !== 5'd16)
      $display("FAIL edgewin_meas: got pv=%0b hp=%0d want 1 16", o_pv, o_hp);
    else n_pass++;
    relock("edgewin");
`ifdef CLK_PERIOD_MON_STICKY_ERR_EN
    n_total++;
    if (err_sticky !== 1'b1) $display("FAIL relock_err: got %0b want 1", err_sticky);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    @(negedge clk_in);
    sig_in = ~sig_in;
    repeat (2) @(negedge clk_in);
    n_total++;
    if (locked !== 1'b1 || (rise_pulse | fall_pulse) !== 1'b1)
      $display("FAIL ar_pre: got lk=%0b pulse=%0b want 1 1", locked, rise_pulse | fall_pulse);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({rise_pulse, fall_pulse, period_valid, locked, timeout} !== 5'b0)
      $display("FAIL ar_flags: got %05b want 00000",
               {rise_pulse, fall_pulse, period_valid, locked, timeout});
    else n_pass++;
    n_total++;
    if (half_period !== '0) $display("FAIL ar_hp: got %0d want 0", half_period);
    else n_pass++;
`ifdef CLK_PERIOD_MON_STICKY_ERR_EN
    n_total++;
    if (err_sticky !== 1'b0) $display("FAIL ar_err: got %0b want 0", err_sticky);
    else n_pass++;
`endif
    @(negedge clk_in);
    sig_in = 1'b1;
    reset  = 1'b0;
    repeat (2) @(negedge clk_in);
    n_total++;
    if (rise_pulse !== 1'b1) $display("FAIL ar_rise: got %0b want 1", rise_pulse);
    else n_pass++;
    @(negedge clk_in);
    n_total++;
    if (period_valid !== 1'b0 || rise_pulse !== 1'b0)
      $display("FAIL ar_first_edge: got pv=%0b rise=%0b want 0 0", period_valid, rise_pulse);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_tolerance();
    test_loss();
    test_timeout();
    test_edge_wins();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
